warp_inst_sequencer: RTL



---
 rtl/warp_inst_sequencer_pkg.sv | 17 +
 rtl/warp_inst_sequencer_inflight_counter.sv | 42 ++++
 rtl/warp_inst_sequencer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/warp_inst_sequencer_pkg.sv
// Shared configuration for the warp issue stage: default sizes and the FSM state type.
package warp_inst_sequencer_pkg;

   localparam int DEF_N_INST       = 16;
   localparam int DEF_MAX_WARP     = 4;
   localparam int DEF_WORK_BW      = 16;
   localparam int DEF_VDIM         = 4;
   localparam int DEF_MAX_INFLIGHT = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/warp_inst_sequencer_inflight_counter.sv
// Saturating up/down counter of issued-but-uncommitted work items.
// Saturates at 0 and at MAX; at_cap looks one edge ahead so callers can act on it this cycle.
module warp_inst_sequencer_inflight_counter #(
   parameter int MAX = 4,
   parameter int CW  = $clog2(MAX + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          inc,
   input  logic          dec,
   output logic [CW-1:0] count,
   output logic          at_cap
);

   logic          dec_ok;
   logic          inc_ok;
   logic [CW-1:0] count_nxt;

   always_comb begin
      dec_ok    = dec && (count != '0);
      inc_ok    = inc && ((count != CW'(MAX)) || dec_ok);
      count_nxt = count;
      if (inc_ok && !dec_ok) begin
         count_nxt = count + 1'b1;
      end else if (dec_ok && !inc_ok) begin
         count_nxt = count - 1'b1;
      end
      at_cap = (count_nxt == CW'(MAX));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
      end else begin
         count <= count_nxt;
      end
   end

   // A decrement with nothing outstanding means the producer lost track of a commit.
   underflow_commit : assert property (@(posedge clk) disable iff (!rst_n) !(dec && (count == '0)));

endmodule

// File: rtl/warp_inst_sequencer.sv
// Issue stage: latches one warp descriptor, issues its instructions pc 0..n-1 under an
// inflight cap, and pulses done once every issued instruction has committed.
module warp_inst_sequencer
   import warp_inst_sequencer_pkg::*;
#(
   parameter int N_INST       = DEF_N_INST,
   parameter int MAX_WARP     = DEF_MAX_WARP,
   parameter int WBW          = DEF_WORK_BW,
   parameter int VDIM         = DEF_VDIM,
   parameter int MAX_INFLIGHT = DEF_MAX_INFLIGHT,
   parameter int INST_BW      = $clog2(N_INST + 1),
   parameter int WID_BW       = $clog2(MAX_WARP),
   parameter int IFL_BW       = $clog2(MAX_INFLIGHT + 1)
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      warp_rdy,
   output logic                      warp_ack,
   input  logic [WID_BW-1:0]         i_wid,
   input  logic [VDIM-1:0][WBW-1:0]  i_bofs,
   input  logic [VDIM-1:0][WBW-1:0]  i_aofs,
   input  logic [INST_BW-1:0]        i_ninst,
   output logic                      inst_rdy,
   input  logic                      inst_ack,
   output logic [INST_BW-1:0]        o_pc,
   output logic [WID_BW-1:0]         o_wid,
   output logic [VDIM-1:0][WBW-1:0]  o_bofs,
   output logic [VDIM-1:0][WBW-1:0]  o_aofs,
   input  logic                      inst_commit_dval,
   output logic                      done_dval,
   output logic [WID_BW-1:0]         o_done_wid,
   output state_t                    o_state,
   output logic [IFL_BW-1:0]         o_inflight
);

   // Handshakes: a transfer happens in any cycle where rdy && ack. The rdy side holds rdy
   // and its payload stable until it sees ack; the ack side may respond combinationally.

   state_t               state;
   logic [INST_BW-1:0]   ninst;
   logic                 issue_hs;
   logic                 last_issue;
   logic                 ifl_cap;

   assign warp_ack = i_rst && (state == IDLE) && warp_rdy;
   assign issue_hs = inst_rdy && inst_ack;
   assign o_state  = state;

   // One extra bit so that pc+1 == N_INST is representable rather than wrapping.
   assign last_issue = (({1'b0, o_pc} + (INST_BW + 1)'(1)) == {1'b0, ninst});

   warp_inst_sequencer_inflight_counter #(
      .MAX (MAX_INFLIGHT),
      .CW  (IFL_BW)
   ) inflight_counter (
      .clk    (i_clk),
      .rst_n  (i_rst),
      .inc    (issue_hs),
      .dec    (inst_commit_dval),
      .count  (o_inflight),
      .at_cap (ifl_cap)
   );

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state      <= IDLE;
         inst_rdy   <= 1'b0;
         done_dval  <= 1'b0;
         o_pc       <= '0;
         ninst      <= '0;
         o_wid      <= '0;
         o_bofs     <= '0;
         o_aofs     <= '0;
         o_done_wid <= '0;
      end else begin
         done_dval <= 1'b0;
         case (state)
            IDLE: begin
               if (warp_ack) begin
                  o_wid  <= i_wid;
                  o_bofs <= i_bofs;
                  o_aofs <= i_aofs;
                  ninst  <= i_ninst;
                  o_pc   <= '0;
                  if (i_ninst == '0) begin
                     state      <= DONE;
                     done_dval  <= 1'b1;
                     o_done_wid <= i_wid;
                  end else begin
                     state    <= ISSUE;
                     inst_rdy <= 1'b1;
                  end
               end
            end
            ISSUE: begin
               if (issue_hs) begin
                  if (last_issue) begin
                     inst_rdy <= 1'b0;
                     state    <= DRAIN;
                  end else begin
                     o_pc     <= o_pc + 1'b1;
                     inst_rdy <= !ifl_cap;
                  end
               end else if (!inst_rdy && !ifl_cap) begin
                  // Stalled on the cap: a commit has just made room.
                  inst_rdy <= 1'b1;
               end
            end
            DRAIN: begin
               if (o_inflight == '0) begin
                  state      <= DONE;
                  done_dval  <= 1'b1;
                  o_done_wid <= o_wid;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
